ama_riscv_imm_gen_pipe: RTL
===========================

Name: ama_riscv_imm_gen_pipe

Overview:
Registered, handshaked immediate generator for the decode stage; generalised successor of the combinational imm gen.
- Supports XLEN 32/64 and carries a sideband tag.
- Flow control is valid/ready, with a 2-entry skid buffer so the decode stage can absorb backpressure without a combinational in_ready path.
- Sits between the instruction-fetch register and the decode/execute boundary.

Parameters:
- XLEN, 32: output width; 32 or 64 only; any other value triggers a $fatal at elaboration.
- TAG_W, 8: sideband tag width (e.g. PC index or ROB id); passed through unchanged.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all buffered entries
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- en  in  1  immediate enable; 0 forces the output immediate to 0
- ig_sel  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (only with macro)
- ig_in  in  25  instruction bits [31:7]
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts
- ig_out  out  XLEN  sign/zero-extended immediate
- out_tag  out  TAG_W  tag of the output beat
- out_inv  out  1  ig_sel was illegal for this beat

Behaviour:
- Reset (rst_n low, asynchronous): both entries invalid; out_valid=0, ig_out=0, out_tag=0, out_inv=0, in_ready=1.
- Transfers: input beat accepted when in_valid & in_ready; output beat consumed when out_valid & out_ready.
- Latency: 1 cycle. A beat accepted in cycle N is presented in N+1 if the buffer was empty.
- Immediate is computed combinationally from the input and registered; there is no combinational input-to-output path.
- Format rules (inst bit k = ig_in[k]); sign bit is inst[31], extended to XLEN for I/S/B/J:
  - I = inst[31:20]
  - S = {inst[31:25], inst[11:7]}
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - U = {inst[31:12], 12'h0}, sign-extended from bit 31 when XLEN=64
- Illegal ig_sel (101 without macro, 110, 111): ig_out=0, out_inv=1. The beat is still passed through, never dropped.
- en=0: ig_out=0 and out_inv=0, regardless of ig_sel.
- State machine (entry count):
  - EMPTY: accept -> ONE.
  - ONE: accept and no consume -> TWO; consume and no accept -> EMPTY; both -> ONE.
  - TWO: consume -> ONE.
- in_ready = (state != TWO); it is a registered signal.
- Ordering: strictly FIFO. The skid entry moves to the output register on consume.
- Output hold: while out_valid & !out_ready, ig_out, out_tag and out_inv stay stable.
- Flush: both entries invalidated next cycle and out_valid=0. A beat presented in the same cycle as flush is dropped. Flush takes priority over accept/consume.
- Unused state: never entered; it decodes to EMPTY on the next cycle.

Optional Feature:
- Macro: AMA_RISCV_IMM_GEN_CSR_EN.
- Defined: ig_sel=101 selects the Z format, ig_out = zero-extended inst[19:15] (CSR uimm), out_inv=0.
- Undefined: 101 is illegal, giving ig_out=0 and out_inv=1.

Decomposition:
- Package ama_riscv_imm_gen_pkg holds:
  - ig_sel localparams IG_I_TYPE..IG_Z_TYPE
  - the ig_sel width
  - a function imm_decode(sel, inst, xlen), shared with the bench's reference model.
- One natural sub-module: ama_riscv_skid_buf (2-entry, parametrised payload width = XLEN+TAG_W+1), reusable for other decode paths.

Test Plan:
- XLEN=32, I-type, ig_in from 32'hFFF00000, tag 8'h5A -> next cycle ig_out=32'hFFFFFFFF, out_tag=8'h5A, out_inv=0.
- XLEN=64, U-type, 32'hFFFFF000 -> ig_out=64'hFFFFFFFFFFFFF000; then B-type {7'h7F,13'h0,5'h1F,7'h0} -> ig_out=64'hFFFFFFFFFFFFFFFE.
- Backpressure: out_ready=0, three back-to-back beats -> in_ready drops after beat 2; beat 3 held off. Release out_ready -> beats emerge in order, outputs stable while stalled.
- Illegal sel 3'b111 with en=1 -> ig_out=0, out_inv=1. With the macro, sel 101 on inst[19:15]=5'h1F -> ig_out=32'h1F, out_inv=0.
- Flush with TWO entries and concurrent in_valid -> next cycle out_valid=0, in_ready=1, input beat absent from the output stream.
- rst_n asserted mid-stream (asynchronous, between edges) -> out_valid=0 and in_ready=1 immediately; random 64-beat stream afterwards matches the package model.

Source files
------------

// File: rtl/ama_riscv_imm_gen_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator: format selects,
// skid-buffer states and the immediate decode function (AMA_RISCV_IMM_GEN_CSR_EN adds Z).
package ama_riscv_imm_gen_pkg;

    localparam int IG_SEL_W = 3;

    localparam logic [IG_SEL_W-1:0] IG_I_TYPE = 3'b000;
    localparam logic [IG_SEL_W-1:0] IG_S_TYPE = 3'b001;
    localparam logic [IG_SEL_W-1:0] IG_B_TYPE = 3'b010;
    localparam logic [IG_SEL_W-1:0] IG_J_TYPE = 3'b011;
    localparam logic [IG_SEL_W-1:0] IG_U_TYPE = 3'b100;
    localparam logic [IG_SEL_W-1:0] IG_Z_TYPE = 3'b101;

    typedef enum logic [1:0] {
        SB_EMPTY = 2'b00,
        SB_ONE   = 2'b01,
        SB_TWO   = 2'b10
    } sb_state_t;

    typedef struct packed {
        logic [63:0] imm;
        logic        inv;
    } imm_dec_t;

    // Full 64-bit decode; for xlen 32 the upper half is cleared so callers may slice.
    function automatic imm_dec_t imm_decode(input logic [IG_SEL_W-1:0] sel,
                                            input logic [24:0]         inst_hi,
                                            input int                  xlen);
        logic [31:7] inst;
        imm_dec_t    res;
        inst    = inst_hi;
        res.imm = 64'h0;
        res.inv = 1'b0;
        case (sel)
            IG_I_TYPE: res.imm = {{52{inst[31]}}, inst[31:20]};
            IG_S_TYPE: res.imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            IG_B_TYPE: res.imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IG_J_TYPE: res.imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IG_U_TYPE: res.imm = {{32{inst[31]}}, inst[31:12], 12'h000};
`ifdef AMA_RISCV_IMM_GEN_CSR_EN
            IG_Z_TYPE: res.imm = {59'h0, inst[19:15]};
`endif
            default:   res.inv = 1'b1;
        endcase
        if (xlen == 32) begin
            res.imm[63:32] = 32'h0;
        end
        return res;
    endfunction

endpackage

// File: rtl/ama_riscv_imm_gen_pipe_if.sv
// Producer/consumer bus of the pipelined immediate generator.
interface ama_riscv_imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    import ama_riscv_imm_gen_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                en;
    logic [IG_SEL_W-1:0] ig_sel;
    logic [24:0]         ig_in;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     ig_out;
    logic [TAG_W-1:0]    out_tag;
    logic                out_inv;

    modport master (
        output in_valid, en, ig_sel, ig_in, in_tag, out_ready,
        input  in_ready, out_valid, ig_out, out_tag, out_inv
    );

    modport slave (
        input  in_valid, en, ig_sel, ig_in, in_tag, out_ready,
        output in_ready, out_valid, ig_out, out_tag, out_inv
    );

endinterface

// File: rtl/ama_riscv_imm_gen_pipe_skid_buf.sv
// Two-entry skid buffer: output register plus one skid slot, registered
// in_ready so no combinational path runs from out_ready back to in_ready.
module ama_riscv_skid_buf
    import ama_riscv_imm_gen_pkg::*;
#(
    parameter int W = 41
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    sb_state_t      state_r;
    sb_state_t      state_s;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [W-1:0]   out_data_r;
    logic [W-1:0]   skid_r;
    logic           accept_s;
    logic           consume_s;
    logic           load_out_s;
    logic           load_skid_s;
    logic           out_from_skid_s;

    assign accept_s  = in_valid & in_ready_r;
    assign consume_s = out_valid_r & out_ready;

    // Next entry count and data-movement strobes; flush overrides everything.
    always_comb begin
        state_s         = SB_EMPTY;
        load_out_s      = 1'b0;
        load_skid_s     = 1'b0;
        out_from_skid_s = 1'b0;
        if (flush) begin
            state_s = SB_EMPTY;
        end else begin
            case (state_r)
                SB_EMPTY: begin
                    if (accept_s) begin
                        state_s    = SB_ONE;
                        load_out_s = 1'b1;
                    end else begin
                        state_s = SB_EMPTY;
                    end
                end
                SB_ONE: begin
                    if (accept_s && !consume_s) begin
                        state_s     = SB_TWO;
                        load_skid_s = 1'b1;
                    end else if (consume_s && !accept_s) begin
                        state_s = SB_EMPTY;
                    end else if (accept_s) begin
                        state_s    = SB_ONE;
                        load_out_s = 1'b1;
                    end else begin
                        state_s = SB_ONE;
                    end
                end
                SB_TWO: begin
                    if (consume_s) begin
                        state_s         = SB_ONE;
                        out_from_skid_s = 1'b1;
                    end else begin
                        state_s = SB_TWO;
                    end
                end
                default: state_s = SB_EMPTY;
            endcase
        end
    end

    // State register with handshake flags precomputed from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= SB_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s != SB_TWO);
            out_valid_r <= (state_s == SB_ONE) || (state_s == SB_TWO);
        end
    end

    // Payload registers; the skid entry drains into the output slot on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r <= '0;
            skid_r     <= '0;
        end else begin
            if (load_out_s) begin
                out_data_r <= in_data;
            end else if (out_from_skid_s) begin
                out_data_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= in_data;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: rtl/ama_riscv_imm_gen_pipe.sv
// Registered valid/ready immediate generator for decode (XLEN 32/64, tag sideband).
// Define AMA_RISCV_IMM_GEN_CSR_EN to enable the Z (CSR uimm) format on ig_sel 101.
module ama_riscv_imm_gen_pipe
    import ama_riscv_imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    ama_riscv_imm_gen_pipe_if.slave bus
);

    localparam int PW = XLEN + TAG_W + 1;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $fatal(1, "ama_riscv_imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    imm_dec_t        dec_s;
    logic [XLEN-1:0] imm_s;
    logic            inv_s;
    logic            unused_imm_s;
    logic [PW-1:0]   in_data_s;
    logic [PW-1:0]   out_data_s;

    // Decode the incoming beat; a disabled generator yields a clean zero.
    always_comb begin
        dec_s = imm_decode(bus.ig_sel, bus.ig_in, XLEN);
        if (bus.en) begin
            imm_s = dec_s.imm[XLEN-1:0];
            inv_s = dec_s.inv;
        end else begin
            imm_s = '0;
            inv_s = 1'b0;
        end
    end

    assign unused_imm_s = ^dec_s.imm;
    assign in_data_s    = {imm_s, bus.in_tag, inv_s};

    ama_riscv_skid_buf #(
        .W(PW)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_data_s),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data_s)
    );

    assign {bus.ig_out, bus.out_tag, bus.out_inv} = out_data_s;

endmodule
